// File: rtl/cntr8_ctrl_pkg.sv
// cntr8_ctrl_pkg: shared constants for the cntr8 command controller.
// State encoding is kept as plain 3-bit localparams so older code that
// compares raw state values keeps working.
package cntr8_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_INC  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACK  = 3'd4;

  localparam logic CMD_INC  = 1'b0;
  localparam logic CMD_LOAD = 1'b1;

endpackage

// File: rtl/cntr8.sv
// cntr8: loadable up-counter shared by all requesters of cntr8_ctrl.
// Load has priority over increment; the counter wraps naturally at all-ones.
module cntr8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              load,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  // Counter register: load wins over inc, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out <= '0;
    end else if (load) begin
      d_out <= d_in;
    end else if (inc) begin
      d_out <= d_out + DATA_W'(1);
    end
  end

endmodule

// File: rtl/cntr8_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req starting at ptr
// and wrapping to 0; the first set bit wins. The pointer itself is owned by
// the caller so it only moves when a grant is actually taken.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // Walk the requesters in priority order from ptr and keep the first hit
  always_comb begin
    int cand;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = PTR_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cntr8_ctrl.sv
// cntr8_ctrl: round-robin command controller for one shared cntr8.
// Each requester asks for either a LOAD of a value or a burst of k
// increments. One command runs at a time; when it finishes the owner gets a
// one-cycle ack with the resulting counter value on o_result.
module cntr8_ctrl
  import cntr8_ctrl_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_cmd,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]       o_result,
  output logic                    o_busy,
  output logic                    o_inc,
  output logic                    o_load,
  output logic [DATA_W-1:0]       o_d_in,
  input  logic [DATA_W-1:0]       i_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [STATE_W-1:0] state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  remaining;
  logic               armed;

  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic               win_cmd;
  logic [DATA_W-1:0]  win_data;
  logic               grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req    (i_req),
    .ptr    (ptr),
    .valid  (win_valid),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

  assign win_cmd  = i_cmd[win_idx];
  assign win_data = i_data[win_idx*DATA_W +: DATA_W];

  // armed is cleared by reset, so no grant can leak out while reset_n is low
  assign grant  = (state == ST_IDLE) && armed && win_valid;
  assign o_busy = (state != ST_IDLE);

  // Main FSM; the command type is carried by the state itself (LOAD vs INC/WAIT)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      data_q    <= '0;
      remaining <= '0;
      armed     <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner     <= win_idx;
            data_q    <= win_data;
            remaining <= win_data;
            ptr       <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            if (win_cmd == CMD_LOAD) begin
              state <= ST_LOAD;
            end else if (win_data == '0) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_INC;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT;
        end
        ST_INC: begin
          remaining <= remaining - DATA_W'(1);
          if (remaining == DATA_W'(1)) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture the settled counter on entry to ACK so o_result is valid alongside the ack pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_result <= '0;
    end else if (state == ST_WAIT) begin
      o_result <= i_cnt;
    end
  end

  // Decode grant, counter commands and ack from the current state
  always_comb begin
    o_gnt  = '0;
    o_ack  = '0;
    o_inc  = 1'b0;
    o_load = 1'b0;
    o_d_in = '0;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          o_gnt = win_onehot;
        end
      end
      ST_LOAD: begin
        o_load = 1'b1;
        o_d_in = data_q;
      end
      ST_INC: begin
        o_inc = 1'b1;
      end
      ST_ACK: begin
        o_ack[owner] = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cntr8_ctrl.sv
// tb_cntr8_ctrl: self-checking bench for cntr8_ctrl driving a real cntr8.
// Directed scenarios followed by random command traffic, checked against a
// simple arithmetic model of the counter and the round-robin rule.
module tb_cntr8_ctrl;
  import cntr8_ctrl_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  i_req;
  logic [1:0]  i_cmd;
  logic [15:0] i_data;
  logic [1:0]  o_gnt;
  logic [1:0]  o_ack;
  logic [7:0]  o_result;
  logic        o_busy;
  logic        o_inc;
  logic        o_load;
  logic [7:0]  o_d_in;
  logic [7:0]  i_cnt;

  int tests_run  = 0;
  int fail_count = 0;
  int cycle      = 0;

  logic [1:0] req_drv;
  logic [1:0] cmd_drv;
  logic [7:0] data_drv [2];

  int model_cnt;
  int model_ptr;
  int last_who;
  int last_gnt_cycle;
  int last_ack_cycle;

  cntr8_ctrl #(
    .N_REQ  (2),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_cmd    (i_cmd),
    .i_data   (i_data),
    .o_gnt    (o_gnt),
    .o_ack    (o_ack),
    .o_result (o_result),
    .o_busy   (o_busy),
    .o_inc    (o_inc),
    .o_load   (o_load),
    .o_d_in   (o_d_in),
    .i_cnt    (i_cnt)
  );

  cntr8 #(
    .DATA_W (8)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (o_inc),
    .load    (o_load),
    .d_in    (o_d_in),
    .d_out   (i_cnt)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle count used to measure latencies
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit req, input bit cmd, input logic [7:0] data);
    req_drv[idx]         = req;
    cmd_drv[idx]         = cmd;
    data_drv[idx]        = data;
    i_req[idx]           = req;
    i_cmd[idx]           = cmd;
    i_data[idx*8 +: 8]   = data;
  endtask

  // Round-robin rule: the requester at the pointer wins if pending, else the other one
  function automatic int modelPick(input logic [1:0] pend, input int p);
    if (pend[p]) return p;
    if (pend[1-p]) return 1 - p;
    return -1;
  endfunction

  // Wait for the next grant, then follow that command to its ack and check everything
  task automatic serveOne(input string tag, input bit keep);
    int exp_idx, exp_lat, t_gnt, waited, inc_seen, load_seen, bad;
    logic [7:0] exp_k;
    bit exp_cmd;
    exp_idx = modelPick(req_drv, model_ptr);
    waited = 0;
    while (o_gnt == 2'b00 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, ".gnt"}, 32'(o_gnt), (exp_idx < 0) ? 32'd0 : (32'd1 << exp_idx));
    if (o_gnt == 2'b00 || exp_idx < 0) begin
      last_who = -1;
      return;
    end
    checkOutput({tag, ".busy_at_gnt"}, 32'(o_busy), 32'd0);
    t_gnt          = cycle;
    last_gnt_cycle = cycle;
    last_who       = exp_idx;
    exp_cmd        = cmd_drv[exp_idx];
    exp_k          = data_drv[exp_idx];
    model_ptr      = (exp_idx + 1) % 2;
    if (exp_cmd == CMD_LOAD) begin
      model_cnt = exp_k;
      exp_lat   = 3;
    end else begin
      model_cnt = (model_cnt + exp_k) % 256;
      exp_lat   = exp_k + 2;
    end
    // The command is committed: disturbing the inputs now must not matter
    @(posedge clk);
    #1;
    i_cmd[exp_idx]         = ~exp_cmd;
    i_data[exp_idx*8 +: 8] = 8'($urandom);
    inc_seen  = 0;
    load_seen = 0;
    bad       = 0;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
      if (o_inc) inc_seen++;
      if (o_load) begin
        load_seen++;
        if (o_d_in !== exp_k) bad++;
      end else if (o_d_in !== 8'h00) begin
        bad++;
      end
      if (o_inc && o_load) bad++;
    end while (o_ack == 2'b00 && waited < exp_lat + 5);
    last_ack_cycle = cycle;
    checkOutput({tag, ".ack"}, 32'(o_ack), 32'd1 << exp_idx);
    checkOutput({tag, ".latency"}, cycle - t_gnt, exp_lat);
    checkOutput({tag, ".inc_cycles"}, inc_seen, (exp_cmd == CMD_INC) ? 32'(exp_k) : 32'd0);
    checkOutput({tag, ".load_cycles"}, load_seen, (exp_cmd == CMD_LOAD) ? 32'd1 : 32'd0);
    checkOutput({tag, ".cmd_rules"}, bad, 32'd0);
    checkOutput({tag, ".result"}, 32'(o_result), model_cnt);
    checkOutput({tag, ".busy_at_ack"}, 32'(o_busy), 32'd1);
    applyStimulus(exp_idx, keep, cmd_drv[exp_idx], data_drv[exp_idx]);
  endtask

  // Directed scenarios, random traffic, then reset during a burst
  initial begin
    int waited, inc_count, ack_seen, prev_ack, ridx;
    bit rc;
    logic [7:0] rd;

    reset_n = 1'b0;
    i_req   = '0;
    i_cmd   = '0;
    i_data  = '0;
    req_drv = '0;
    cmd_drv = '0;
    data_drv[0] = '0;
    data_drv[1] = '0;
    model_cnt = 0;
    model_ptr = 0;
    last_who = -1;
    last_gnt_cycle = 0;
    last_ack_cycle = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset.outputs", {o_gnt, o_ack, o_inc, o_load, o_busy, o_d_in}, 32'd0);
    checkOutput("reset.result", 32'(o_result), 32'd0);
    checkOutput("reset.counter", 32'(i_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // LOAD 0x2C from req0, then INC 5 from req1
    applyStimulus(0, 1'b1, CMD_LOAD, 8'h2C);
    serveOne("t2.load2c", 1'b0);
    checkOutput("t2.result", 32'(o_result), 32'h2C);
    applyStimulus(1, 1'b1, CMD_INC, 8'd5);
    serveOne("t3.inc5", 1'b0);
    checkOutput("t3.result", 32'(o_result), 32'h31);
    @(negedge clk);
    checkOutput("t3.result_holds", 32'(o_result), 32'h31);

    // Asynchronous reset mid-cycle clears everything at once
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t1.outputs", {o_gnt, o_ack, o_inc, o_load, o_busy}, 32'd0);
    checkOutput("t1.result", 32'(o_result), 32'd0);
    checkOutput("t1.counter", 32'(i_cnt), 32'd0);
    model_cnt = 0;
    model_ptr = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Both requesters held high with INC 1: grants alternate starting at req0
    applyStimulus(0, 1'b1, CMD_INC, 8'd1);
    applyStimulus(1, 1'b1, CMD_INC, 8'd1);
    prev_ack = 0;
    for (int i = 0; i < 4; i++) begin
      serveOne($sformatf("t4.alt%0d", i), 1'b1);
      checkOutput($sformatf("t4.order%0d", i), last_who, i % 2);
      if (i > 0) checkOutput($sformatf("t4.gap%0d", i), last_gnt_cycle - prev_ack, 32'd1);
      prev_ack = last_ack_cycle;
    end
    checkOutput("t4.result", 32'(o_result), 32'd4);
    applyStimulus(0, 1'b0, CMD_INC, 8'd0);
    applyStimulus(1, 1'b0, CMD_INC, 8'd0);
    repeat (2) @(negedge clk);
    checkOutput("t4.idle_no_req", {o_busy, o_gnt}, 32'd0);

    // Wrap 0xFE + 3, empty burst, and the largest burst
    applyStimulus(0, 1'b1, CMD_LOAD, 8'hFE);
    serveOne("t5.loadfe", 1'b0);
    applyStimulus(1, 1'b1, CMD_INC, 8'd3);
    serveOne("t5.inc3", 1'b0);
    checkOutput("t5.wrap", 32'(o_result), 32'h01);
    applyStimulus(0, 1'b1, CMD_INC, 8'd0);
    serveOne("t5.inc0", 1'b0);
    checkOutput("t5.inc0_result", 32'(o_result), 32'h01);
    applyStimulus(1, 1'b1, CMD_INC, 8'd255);
    serveOne("t5.inc255", 1'b0);
    checkOutput("t5.inc255_result", 32'(o_result), 32'h00);

    // Random traffic with contention
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_drv[i] && $urandom_range(0, 1) == 1) begin
          rc = 1'($urandom_range(0, 1));
          rd = rc ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
          applyStimulus(i, 1'b1, rc, rd);
        end
      end
      if (req_drv == 2'b00) begin
        ridx = $urandom_range(0, 1);
        applyStimulus(ridx, 1'b1, CMD_INC, 8'($urandom_range(0, 6)));
      end
      serveOne($sformatf("rnd%0d", r), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      if (req_drv != 2'b00) serveOne($sformatf("drain%0d", i), 1'b0);
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of an INC 5 burst from req0
    applyStimulus(0, 1'b1, CMD_INC, 8'd5);
    waited = 0;
    while (o_gnt == 2'b00 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t6.gnt", 32'(o_gnt), 32'd1);
    @(posedge clk);
    #1;
    inc_count = 0;
    waited = 0;
    while (inc_count < 2 && waited < 20) begin
      @(negedge clk);
      waited++;
      if (o_inc) inc_count++;
    end
    checkOutput("t6.incs_before_reset", inc_count, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6.outputs", {o_gnt, o_ack, o_inc, o_load, o_busy}, 32'd0);
    checkOutput("t6.counter", 32'(i_cnt), 32'd0);
    applyStimulus(1, 1'b1, CMD_INC, 8'd2);
    ack_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_ack != 2'b00 || o_gnt != 2'b00) ack_seen++;
    end
    checkOutput("t6.quiet_in_reset", ack_seen, 32'd0);
    model_cnt = 0;
    model_ptr = 0;
    reset_n = 1'b1;
    serveOne("t6.after0", 1'b0);
    checkOutput("t6.first_after_reset", last_who, 32'd0);
    serveOne("t6.after1", 1'b0);
    checkOutput("t6.final_result", 32'(o_result), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
